// File: rtl/rf_pkg.sv
// Shared types and default constants for the secure register file.
// The privileged bit index and default parameters live here so sub-blocks agree.
package rf_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        ALERT   = 2'd1,
        LOCKOUT = 2'd2
    } rf_state_t;

    localparam int PRIV_BIT      = 11;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_LOCK_BASE = 13;
    localparam int DEF_NRD       = 2;
    localparam int DEF_MAX_VIOL  = 3;

endpackage

// File: rtl/rf_violation_mon.sv
// Violation counter and NORMAL/ALERT/LOCKOUT state machine.
// An unprivileged clear request is itself treated as a violation.
module rf_violation_mon
    import rf_pkg::*;
#(
    parameter int MAX_VIOL = DEF_MAX_VIOL,
    parameter int CW       = $clog2(MAX_VIOL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          viol,
    input  logic          clr_req,
    input  logic          priv,
    output logic [1:0]    state,
    output logic [CW-1:0] count,
    output logic          viol_pulse
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_VIOL);

    rf_state_t     state_q;
    rf_state_t     state_d;
    logic [CW-1:0] count_d;
    logic          clr;
    logic          viol_eff;

    assign clr = clr_req && priv;
    // Once locked out, nothing counts as a further violation.
    assign viol_eff = (viol || (clr_req && !priv)) && (state_q != LOCKOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NORMAL;
            count      <= '0;
            viol_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            count      <= count_d;
            viol_pulse <= viol_eff;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count;
        if (clr) begin
            count_d = '0;
            state_d = NORMAL;
        end else begin
            if (viol_eff && (count < MAX_CNT)) begin
                count_d = count + CW'(1);
            end
            case (state_q)
                NORMAL: begin
                    if (count_d >= MAX_CNT) begin
                        state_d = LOCKOUT;
                    end else if (count_d != '0) begin
                        state_d = ALERT;
                    end
                end
                ALERT: begin
                    if (count_d >= MAX_CNT) begin
                        state_d = LOCKOUT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        state = state_q;
    end

endmodule

// File: rtl/secure_reg_file.sv
// Multi-port register file with a privileged upper address window and
// violation-driven lockout. Reads are registered with one cycle of latency.
module secure_reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LOCK_BASE = DEF_LOCK_BASE,
    parameter int NRD       = DEF_NRD,
    parameter int MAX_VIOL  = DEF_MAX_VIOL
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NRD*$clog2(DEPTH)-1:0]       RF_RADR,
    input  logic                               RF_RD_EN,
    output logic [NRD*DATA_W-1:0]              RF_RDATA,
    output logic                               RF_RVALID,
    input  logic                               RF_EN,
    input  logic [$clog2(DEPTH)-1:0]           RF_WA,
    input  logic [DATA_W-1:0]                  RF_WD,
    input  logic [11:0]                        U_ID,
    input  logic                               RF_CLR_LOCK,
    output logic [11:0]                        RF_UID_OUT,
    output logic                               RF_VIOL,
    output logic [$clog2(MAX_VIOL+1)-1:0]      RF_VIOL_CNT,
    output logic                               RF_LOCKOUT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LOCK_ADR = (AW + 1)'(LOCK_BASE);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [AW-1:0]     radr [NRD];
    logic [NRD-1:0]    port_locked;
    logic              read_viol;
    logic              write_viol;
    logic              wr_locked;
    logic              wr_commit;
    logic              priv;
    logic              lockout;
    logic [1:0]        state;
    rf_state_t         state_now;
    logic              unused_uid;

    assign priv       = U_ID[PRIV_BIT];
    assign unused_uid = ^U_ID[PRIV_BIT-1:0];
    assign state_now  = rf_state_t'(state);
    assign lockout    = (state_now == LOCKOUT);
    assign RF_LOCKOUT = lockout;
    assign RF_UID_OUT = regs[1][11:0];

    assign wr_locked  = ({1'b0, RF_WA} >= LOCK_ADR);
    assign write_viol = RF_EN && wr_locked && !priv;
    // Address 0 is hardwired to zero, so its writes vanish silently.
    assign wr_commit  = RF_EN && (RF_WA != '0) && !lockout && (!wr_locked || priv);

    always_comb begin
        read_viol   = 1'b0;
        port_locked = '0;
        for (int p = 0; p < NRD; p++) begin
            radr[p]        = RF_RADR[p*AW +: AW];
            port_locked[p] = ({1'b0, radr[p]} >= LOCK_ADR);
            if (RF_RD_EN && port_locked[p] && !priv) begin
                read_viol = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[RF_WA] <= RF_WD;
        end
    end

    // Reads sample the pre-write contents, so same-address read/write returns old data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RF_RDATA  <= '0;
            RF_RVALID <= 1'b0;
        end else begin
            RF_RVALID <= RF_RD_EN;
            if (RF_RD_EN) begin
                for (int p = 0; p < NRD; p++) begin
                    RF_RDATA[p*DATA_W +: DATA_W] <=
                        (lockout || (port_locked[p] && !priv)) ? '0 : regs[radr[p]];
                end
            end
        end
    end

    rf_violation_mon #(
        .MAX_VIOL (MAX_VIOL)
    ) u_mon (
        .clk        (CLK),
        .rst        (RST),
        .viol       (write_viol || read_viol),
        .clr_req    (RF_CLR_LOCK),
        .priv       (priv),
        .state      (state),
        .count      (RF_VIOL_CNT),
        .viol_pulse (RF_VIOL)
    );

endmodule

// File: tb/tb_secure_reg_file.sv
// Self-checking bench for secure_reg_file: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_secure_reg_file;

    localparam int DW  = 16;
    localparam int NRD = 2;
    localparam int AW  = 4;
    localparam int LB  = 13;
    localparam int MV  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] radr;
    logic              rd_en;
    logic [NRD*DW-1:0] rdata;
    logic              rvalid;
    logic              en;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [11:0]       uid;
    logic              clr_lock;
    logic [11:0]       uid_out;
    logic              viol;
    logic [1:0]        viol_cnt;
    logic              lockout;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0]     m_mem [16];
    logic [NRD*DW-1:0] m_rdata;
    logic              m_rvalid;
    logic              m_viol;
    int                m_cnt;

    always #5 clk = ~clk;

    secure_reg_file dut (
        .CLK         (clk),
        .RST         (rst),
        .RF_RADR     (radr),
        .RF_RD_EN    (rd_en),
        .RF_RDATA    (rdata),
        .RF_RVALID   (rvalid),
        .RF_EN       (en),
        .RF_WA       (wa),
        .RF_WD       (wd),
        .U_ID        (uid),
        .RF_CLR_LOCK (clr_lock),
        .RF_UID_OUT  (uid_out),
        .RF_VIOL     (viol),
        .RF_VIOL_CNT (viol_cnt),
        .RF_LOCKOUT  (lockout)
    );

    function automatic void model_reset();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_viol   = 1'b0;
        m_cnt    = 0;
    endfunction

    task automatic idle();
        en = 1'b0; rd_en = 1'b0; clr_lock = 1'b0;
        uid = 12'h000; radr = '0; wa = '0; wd = '0;
    endtask

    // Lockout in the model is simply "the count has saturated".
    task automatic tick();
        logic              priv;
        logic              locked;
        logic              bad;
        logic [NRD*DW-1:0] nrd;
        int                a;
        priv   = uid[11];
        locked = (m_cnt == MV);
        bad    = 1'b0;
        nrd    = m_rdata;
        if (rd_en) begin
            for (int p = 0; p < NRD; p++) begin
                a = int'(radr[p*AW +: AW]);
                if (a >= LB && !priv) bad = 1'b1;
                nrd[p*DW +: DW] = (locked || (a >= LB && !priv)) ? '0 : m_mem[a];
            end
        end
        if (en && int'(wa) >= LB && !priv) bad = 1'b1;
        if (clr_lock && !priv) bad = 1'b1;
        if (locked) bad = 1'b0;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_rdata  = nrd;
            m_rvalid = rd_en;
            if (en && wa != 0 && !locked && (int'(wa) < LB || priv)) m_mem[wa] = wd;
            m_viol = bad;
            if (clr_lock && priv) m_cnt = 0;
            else if (bad && m_cnt < MV) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #12;
        model_reset();
        n_cmp++; if (rdata !== '0) begin n_err++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid); end
        n_cmp++; if (viol !== 1'b0) begin n_err++; $display("[TB] FAIL reset_viol: got %b want 0", viol); end
        n_cmp++; if (viol_cnt !== 2'd0) begin n_err++; $display("[TB] FAIL reset_cnt: got %0d want 0", viol_cnt); end
        n_cmp++; if (lockout !== 1'b0) begin n_err++; $display("[TB] FAIL reset_lockout: got %b want 0", lockout); end
        n_cmp++; if (uid_out !== 12'h000) begin n_err++; $display("[TB] FAIL reset_uid_out: got %h want 000", uid_out); end
        rst = 1'b0;
    endtask

    task automatic test_basic_rw();
        idle(); en = 1'b1; wa = 4'd5; wd = 16'hBEEF; tick();
        idle(); rd_en = 1'b1; radr = {4'd0, 4'd5}; tick();
        n_cmp++; if (rdata !== 32'h0000_BEEF) begin n_err++; $display("[TB] FAIL basic_read: got %h want 0000beef", rdata); end
        n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("[TB] FAIL basic_rvalid: got %b want 1", rvalid); end
        n_cmp++; if (viol !== 1'b0) begin n_err++; $display("[TB] FAIL basic_viol: got %b want 0", viol); end
        idle(); rd_en = 1'b1; radr = {4'd0, 4'd5}; en = 1'b1; wa = 4'd5; wd = 16'h1111; tick();
        n_cmp++; if (rdata[15:0] !== 16'hBEEF) begin n_err++; $display("[TB] FAIL same_addr_old: got %h want beef", rdata[15:0]); end
        idle(); rd_en = 1'b1; radr = {4'd0, 4'd5}; en = 1'b1; wa = 4'd0; wd = 16'hFFFF; tick();
        n_cmp++; if (rdata !== 32'h0000_1111) begin n_err++; $display("[TB] FAIL addr0_read: got %h want 00001111", rdata); end
        n_cmp++; if (viol !== 1'b0) begin n_err++; $display("[TB] FAIL addr0_viol: got %b want 0", viol); end
        idle(); tick();
        n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL idle_rvalid: got %b want 0", rvalid); end
        n_cmp++; if (rdata !== 32'h0000_1111) begin n_err++; $display("[TB] FAIL rdata_hold: got %h want 00001111", rdata); end
        idle(); en = 1'b1; wa = 4'd5; wd = 16'hBEEF; tick();
    endtask

    task automatic test_priv_violation();
        idle(); en = 1'b1; wa = 4'd14; wd = 16'h1234; tick();
        n_cmp++; if (viol !== 1'b1) begin n_err++; $display("[TB] FAIL wviol_pulse: got %b want 1", viol); end
        n_cmp++; if (viol_cnt !== 2'd1) begin n_err++; $display("[TB] FAIL wviol_cnt: got %0d want 1", viol_cnt); end
        n_cmp++; if (lockout !== 1'b0) begin n_err++; $display("[TB] FAIL wviol_lockout: got %b want 0", lockout); end
        idle(); uid = 12'h800; rd_en = 1'b1; radr = {4'd0, 4'd14}; tick();
        n_cmp++; if (rdata[15:0] !== 16'h0000) begin n_err++; $display("[TB] FAIL dropped_write: got %h want 0000", rdata[15:0]); end
        n_cmp++; if (viol !== 1'b0) begin n_err++; $display("[TB] FAIL pulse_once: got %b want 0", viol); end
        n_cmp++; if (viol_cnt !== 2'd1) begin n_err++; $display("[TB] FAIL priv_read_cnt: got %0d want 1", viol_cnt); end
    endtask

    task automatic test_dual_locked_read();
        idle(); uid = 12'h800; en = 1'b1; wa = 4'd13; wd = 16'h1313; tick();
        wa = 4'd15; wd = 16'h1515; tick();
        wa = 4'd2;  wd = 16'h0055; tick();
        n_cmp++; if (viol_cnt !== 2'd1) begin n_err++; $display("[TB] FAIL priv_write_cnt: got %0d want 1", viol_cnt); end
        idle(); rd_en = 1'b1; radr = {4'd15, 4'd13}; tick();
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("[TB] FAIL dual_locked_data: got %h want 0", rdata); end
        n_cmp++; if (viol_cnt !== 2'd2) begin n_err++; $display("[TB] FAIL dual_locked_cnt: got %0d want 2", viol_cnt); end
        idle(); uid = 12'h800; rd_en = 1'b1; radr = {4'd15, 4'd13}; tick();
        n_cmp++; if (rdata !== 32'h1515_1313) begin n_err++; $display("[TB] FAIL priv_locked_read: got %h want 15151313", rdata); end
    endtask

    task automatic test_lockout();
        idle(); rd_en = 1'b1; radr = {4'd2, 4'd13}; tick();
        n_cmp++; if (rdata !== 32'h0055_0000) begin n_err++; $display("[TB] FAIL mixed_ports: got %h want 00550000", rdata); end
        n_cmp++; if (lockout !== 1'b1) begin n_err++; $display("[TB] FAIL enter_lockout: got %b want 1", lockout); end
        n_cmp++; if (viol_cnt !== 2'd3) begin n_err++; $display("[TB] FAIL lockout_cnt: got %0d want 3", viol_cnt); end
        idle(); uid = 12'h800; en = 1'b1; wa = 4'd2; wd = 16'h00AA; rd_en = 1'b1; radr = {4'd5, 4'd2}; tick();
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("[TB] FAIL lockout_read_zero: got %h want 0", rdata); end
        n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("[TB] FAIL lockout_rvalid: got %b want 1", rvalid); end
        idle(); en = 1'b1; wa = 4'd14; wd = 16'h7777; tick();
        n_cmp++; if (viol !== 1'b0) begin n_err++; $display("[TB] FAIL lockout_no_viol: got %b want 0", viol); end
        n_cmp++; if (viol_cnt !== 2'd3) begin n_err++; $display("[TB] FAIL lockout_cnt_hold: got %0d want 3", viol_cnt); end
    endtask

    task automatic test_clear();
        idle(); clr_lock = 1'b1; tick();
        n_cmp++; if (lockout !== 1'b1) begin n_err++; $display("[TB] FAIL unpriv_clr_lockout: got %b want 1", lockout); end
        n_cmp++; if (viol_cnt !== 2'd3) begin n_err++; $display("[TB] FAIL unpriv_clr_cnt: got %0d want 3", viol_cnt); end
        idle(); uid = 12'h800; clr_lock = 1'b1; tick();
        n_cmp++; if (lockout !== 1'b0) begin n_err++; $display("[TB] FAIL priv_clr_lockout: got %b want 0", lockout); end
        n_cmp++; if (viol_cnt !== 2'd0) begin n_err++; $display("[TB] FAIL priv_clr_cnt: got %0d want 0", viol_cnt); end
        idle(); rd_en = 1'b1; radr = {4'd2, 4'd5}; tick();
        n_cmp++; if (rdata !== 32'h0055_BEEF) begin n_err++; $display("[TB] FAIL retained_data: got %h want 0055beef", rdata); end
    endtask

    task automatic test_uid_reset();
        idle(); en = 1'b1; wa = 4'd1; wd = 16'h0ABC; tick();
        n_cmp++; if (uid_out !== 12'hABC) begin n_err++; $display("[TB] FAIL uid_out: got %h want abc", uid_out); end
        idle(); en = 1'b1; wa = 4'd3; wd = 16'h3333; rd_en = 1'b1; radr = {4'd13, 4'd1}; tick();
        n_cmp++; if (viol_cnt !== 2'd1) begin n_err++; $display("[TB] FAIL pre_reset_cnt: got %0d want 1", viol_cnt); end
        idle(); en = 1'b1; wa = 4'd4; wd = 16'h4444;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++; if ({rdata, rvalid, viol, viol_cnt, lockout, uid_out} !== '0) begin
            n_err++; $display("[TB] FAIL async_reset_outputs: got %h/%b/%b/%0d/%b/%h want all 0", rdata, rvalid, viol, viol_cnt, lockout, uid_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(); uid = 12'h800; rd_en = 1'b1; radr = {4'd4, 4'd3}; tick();
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("[TB] FAIL reset_blocks_commit: got %h want 0", rdata); end
    endtask

    task automatic test_reset_in_lockout();
        for (int i = 0; i < MV; i++) begin
            idle(); rd_en = 1'b1; radr = {4'd13, 4'd13}; tick();
        end
        n_cmp++; if (lockout !== 1'b1) begin n_err++; $display("[TB] FAIL relock: got %b want 1", lockout); end
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++; if (lockout !== 1'b0) begin n_err++; $display("[TB] FAIL reset_exits_lockout: got %b want 0", lockout); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(); en = 1'b1; wa = 4'd6; wd = 16'h0606; tick();
        idle(); rd_en = 1'b1; radr = {4'd0, 4'd6}; tick();
        n_cmp++; if (rdata !== 32'h0000_0606) begin n_err++; $display("[TB] FAIL post_reset_write: got %h want 00000606", rdata); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            uid      = {($urandom_range(0, 1) == 1), 11'($urandom)};
            en       = ($urandom_range(0, 1) == 1);
            wa       = 4'($urandom);
            wd       = 16'($urandom);
            rd_en    = ($urandom_range(0, 2) != 0);
            radr     = 8'($urandom);
            clr_lock = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
            n_cmp++; if (rdata !== m_rdata) begin n_err++; $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", c, rdata, m_rdata); end
            n_cmp++; if (rvalid !== m_rvalid) begin n_err++; $display("[TB] FAIL rand_rvalid[%0d]: got %b want %b", c, rvalid, m_rvalid); end
            n_cmp++; if (viol !== m_viol) begin n_err++; $display("[TB] FAIL rand_viol[%0d]: got %b want %b", c, viol, m_viol); end
            n_cmp++; if (viol_cnt !== 2'(m_cnt)) begin n_err++; $display("[TB] FAIL rand_cnt[%0d]: got %0d want %0d", c, viol_cnt, m_cnt); end
            n_cmp++; if (lockout !== (m_cnt == MV)) begin n_err++; $display("[TB] FAIL rand_lockout[%0d]: got %b want %b", c, lockout, (m_cnt == MV)); end
            n_cmp++; if (uid_out !== m_mem[1][11:0]) begin n_err++; $display("[TB] FAIL rand_uid_out[%0d]: got %h want %h", c, uid_out, m_mem[1][11:0]); end
            rst = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting secure_reg_file bench");
        test_reset();
        test_basic_rw();
        test_priv_violation();
        test_dual_locked_read();
        test_lockout();
        test_clear();
        test_uid_reset();
        test_reset_in_lockout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
